osd_string_scheduler: RTL and testbench

- Controller that sequences the OSD pixel-modify stage. It holds the string to display, the overlay position, colour and glyph size.
- It feeds the modify stage a glyph base address for each character index that stage reports.
- Host-side string and config writes go to shadow copies. A commit makes them active only at a frame boundary, so a frame never mixes old and new settings.
- It sits between the host/register interface and the pixel modifier, in the pix_clk domain.

---
 rtl/osd_pkg.sv | 46 ++++
 rtl/osd_glyph_addr.sv | 25 ++
 rtl/osd_string_scheduler.sv | 179 +++++++++++++++++
 tb/tb_osd_string_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared parameters, derived widths, register selects and FSM states for the
// OSD string scheduler and its glyph address mapper.
package osd_pkg;

  localparam int PAGES         = 2;
  localparam int PNG_W         = 64;
  localparam int PNG_H         = 64;
  localparam int FRAME_W       = 640;
  localparam int FRAME_H       = 480;
  localparam int STRING_LENGTH = 60;
  localparam int DATA_WIDTH    = 24;
  localparam int CHAR_ENCODING = 12;
  localparam int CELL_W        = 8;
  localparam int CELL_H        = 16;
  localparam int CODE_W        = 8;

  localparam int ADDR_W = $clog2(PAGES * PNG_W * PNG_H);
  localparam int X_W    = $clog2(FRAME_W - 2) + 1;
  localparam int Y_W    = $clog2(FRAME_H - 2) + 1;
  localparam int IDX_W  = $clog2(STRING_LENGTH);

  localparam int GLYPHS_PER_ROW = PNG_W / CELL_W;
  localparam int GLYPH_ROWS     = PAGES * PNG_H / CELL_H;
  localparam int NUM_GLYPHS     = GLYPHS_PER_ROW * GLYPH_ROWS;

  // Bit-slice geometry: glyph index splits into row/column, each a power-of-2 shift.
  localparam int COL_W     = $clog2(GLYPHS_PER_ROW);
  localparam int GLYPH_W   = $clog2(NUM_GLYPHS);
  localparam int ROW_SHIFT = $clog2(PNG_W * CELL_H);
  localparam int COL_SHIFT = $clog2(CELL_W);

  localparam logic [2:0] CFG_X     = 3'd0;
  localparam logic [2:0] CFG_Y     = 3'd1;
  localparam logic [2:0] CFG_COLOR = 3'd2;
  localparam logic [2:0] CFG_CW    = 3'd3;
  localparam logic [2:0] CFG_CL    = 3'd4;
  localparam logic [2:0] CFG_EN    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_BLANK    = 2'd3
  } osd_state_e;

endpackage

// File: rtl/osd_glyph_addr.sv
// Combinational mapping from character code to glyph base address in the atlas;
// out-of-range codes or string indices fall back to glyph 0.
module osd_glyph_addr
  import osd_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              idx_ok_i,
  output logic [ADDR_W-1:0] base_o
);

  logic [GLYPH_W-1:0] glyph_s;

  // Row = upper glyph bits, column = lower glyph bits; both scale by constant shifts.
  always_comb begin
    glyph_s = '0;
    if (idx_ok_i && (int'(code_i) < NUM_GLYPHS)) begin
      glyph_s = code_i[GLYPH_W-1:0];
    end else begin
      glyph_s = '0;
    end
    base_o = (ADDR_W'(glyph_s[GLYPH_W-1:COL_W]) << ROW_SHIFT)
           | (ADDR_W'(glyph_s[COL_W-1:0]) << COL_SHIFT);
  end

endmodule

// File: rtl/osd_string_scheduler.sv
// Double-buffered OSD string/config holder: shadow writes become active only at a
// frame boundary, and each character index is turned into a glyph base address.
module osd_string_scheduler
  import osd_pkg::*;
(
  input  logic                     pix_clk,
  input  logic                     rst_n,
  input  logic                     fval,
  input  logic [IDX_W-1:0]         char_count,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic [CODE_W-1:0]        wr_data,
  input  logic                     cfg_wr,
  input  logic [2:0]               cfg_sel,
  input  logic [DATA_WIDTH-1:0]    cfg_data,
  input  logic                     commit_req,
  output logic [ADDR_W-1:0]        pattern_addr,
  output logic [DATA_WIDTH-1:0]    char_color,
  output logic [CHAR_ENCODING-1:0] char_width,
  output logic [CHAR_ENCODING-1:0] char_length,
  output logic [X_W-1:0]           start_x,
  output logic [Y_W-1:0]           start_y,
  output logic                     overlay_en,
  output logic                     commit_ack,
  output logic                     wr_err
);

  osd_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic       apply_s;
  logic       sel_q;
  logic [CODE_W-1:0] bank_q [2][STRING_LENGTH];

  logic [X_W-1:0]           sh_x_q, sh_x_d;
  logic [Y_W-1:0]           sh_y_q, sh_y_d;
  logic [DATA_WIDTH-1:0]    sh_color_q, sh_color_d;
  logic [CHAR_ENCODING-1:0] sh_cw_q, sh_cw_d;
  logic [CHAR_ENCODING-1:0] sh_cl_q, sh_cl_d;
  logic                     sh_en_q, sh_en_d;

  logic [X_W-1:0]           x_q;
  logic [Y_W-1:0]           y_q;
  logic [DATA_WIDTH-1:0]    color_q;
  logic [CHAR_ENCODING-1:0] cw_q, cl_q;
  logic                     en_q, ack_q, err_q;
  logic [ADDR_W-1:0]        addr_q;

  logic                wr_bad_s, cfg_bad_s, idx_ok_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [CODE_W-1:0]   code_s;
  logic [ADDR_W-1:0]   glyph_base_s;

  assign wr_bad_s  = wr_en && (int'(wr_addr) >= STRING_LENGTH);
  assign cfg_bad_s = cfg_wr && (cfg_sel > CFG_EN);
  assign idx_ok_s  = int'(char_count) < STRING_LENGTH;
  assign rd_idx_s  = idx_ok_s ? char_count : '0;
  assign code_s    = bank_q[sel_q][rd_idx_s];

  osd_glyph_addr u_glyph_addr (
    .code_i   (code_s),
    .idx_ok_i (idx_ok_s),
    .base_o   (glyph_base_s)
  );

  // Shadow config next-state from host register writes.
  always_comb begin
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_color_d = sh_color_q;
    sh_cw_d    = sh_cw_q;
    sh_cl_d    = sh_cl_q;
    sh_en_d    = sh_en_q;
    if (cfg_wr) begin
      case (cfg_sel)
        CFG_X:     sh_x_d     = cfg_data[X_W-1:0];
        CFG_Y:     sh_y_d     = cfg_data[Y_W-1:0];
        CFG_COLOR: sh_color_d = cfg_data;
        CFG_CW:    sh_cw_d    = cfg_data[CHAR_ENCODING-1:0];
        CFG_CL:    sh_cl_d    = cfg_data[CHAR_ENCODING-1:0];
        CFG_EN:    sh_en_d    = cfg_data[0];
        default:   sh_en_d    = sh_en_q;
      endcase
    end else begin
      sh_en_d = sh_en_q;
    end
  end

  // Frame tracking FSM and commit arbitration; a commit never lands inside ACTIVE.
  always_comb begin
    state_d   = state_q;
    apply_s   = pending_q && (state_q != ST_ACTIVE) && !fval;
    pending_d = commit_req || (pending_q && !apply_s);
    case (state_q)
      ST_IDLE:     state_d = ST_IDLE;
      ST_WAIT_SOF: state_d = fval ? ST_ACTIVE : ST_WAIT_SOF;
      ST_ACTIVE:   state_d = fval ? ST_ACTIVE : ST_BLANK;
      ST_BLANK:    state_d = fval ? ST_ACTIVE : ST_BLANK;
      default:     state_d = ST_IDLE;
    endcase
    if (apply_s && !sh_en_d) begin
      state_d = ST_IDLE;
    end else if (apply_s && (state_q == ST_IDLE)) begin
      state_d = ST_WAIT_SOF;
    end else begin
      state_d = state_d;
    end
  end

  // Control, shadow config and active (output) registers.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      sel_q      <= 1'b0;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_color_q <= '0;
      // Untouched width/length commit back to the native cell size.
      sh_cw_q    <= CHAR_ENCODING'(CELL_W);
      sh_cl_q    <= CHAR_ENCODING'(CELL_H);
      sh_en_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '1;
      color_q    <= '0;
      cw_q       <= CHAR_ENCODING'(CELL_W);
      cl_q       <= CHAR_ENCODING'(CELL_H);
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_color_q <= sh_color_d;
      sh_cw_q    <= sh_cw_d;
      sh_cl_q    <= sh_cl_d;
      sh_en_q    <= sh_en_d;
      ack_q      <= apply_s;
      err_q      <= wr_bad_s || cfg_bad_s;
      addr_q     <= en_q ? glyph_base_s : '0;
      if (apply_s) begin
        sel_q   <= ~sel_q;
        x_q     <= sh_x_d;
        y_q     <= sh_en_d ? sh_y_d : '1;
        color_q <= sh_color_d;
        cw_q    <= sh_cw_d;
        cl_q    <= sh_cl_d;
        en_q    <= sh_en_d;
      end
    end
  end

  // String banks; the write target flips with sel_q on the same edge, so a
  // write coinciding with a commit ends up in the newly active bank.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < STRING_LENGTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (wr_en && !wr_bad_s) begin
      bank_q[~sel_q][wr_addr] <= wr_data;
    end
  end

  assign pattern_addr = addr_q;
  assign char_color   = color_q;
  assign char_width   = cw_q;
  assign char_length  = cl_q;
  assign start_x      = x_q;
  assign start_y      = y_q;
  assign overlay_en   = en_q;
  assign commit_ack   = ack_q;
  assign wr_err       = err_q;

endmodule

// File: tb/tb_osd_string_scheduler.sv
// Directed self-checking bench for osd_string_scheduler.
module tb_osd_string_scheduler;
  import osd_pkg::*;

  logic                     pix_clk = 1'b0;
  logic                     rst_n;
  logic                     fval;
  logic [IDX_W-1:0]         char_count;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_addr;
  logic [CODE_W-1:0]        wr_data;
  logic                     cfg_wr;
  logic [2:0]               cfg_sel;
  logic [DATA_WIDTH-1:0]    cfg_data;
  logic                     commit_req;
  logic [ADDR_W-1:0]        pattern_addr;
  logic [DATA_WIDTH-1:0]    char_color;
  logic [CHAR_ENCODING-1:0] char_width;
  logic [CHAR_ENCODING-1:0] char_length;
  logic [X_W-1:0]           start_x;
  logic [Y_W-1:0]           start_y;
  logic                     overlay_en;
  logic                     commit_ack;
  logic                     wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  osd_string_scheduler dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .fval(fval), .char_count(char_count),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cfg_wr(cfg_wr),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .commit_req(commit_req),
    .pattern_addr(pattern_addr), .char_color(char_color), .char_width(char_width),
    .char_length(char_length), .start_x(start_x), .start_y(start_y),
    .overlay_en(overlay_en), .commit_ack(commit_ack), .wr_err(wr_err)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic wr_str(input int a, input int d);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = CODE_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_cfg(input logic [2:0] s, input int d);
    cfg_wr = 1'b1; cfg_sel = s; cfg_data = DATA_WIDTH'(d);
    tick();
    cfg_wr = 1'b0;
  endtask

  // Pulse commit_req and wait (bounded) for the ack.
  task automatic commit_wait(input string name);
    logic got;
    got = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (commit_ack) begin got = 1'b1; break; end
    end
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL %s_ack: no commit_ack within 10 cycles", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fval = 1'b0; char_count = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_wr = 1'b0; cfg_sel = '0; cfg_data = '0; commit_req = 1'b0;
    #22;
    n_checks++; if (pattern_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", pattern_addr); end
    n_checks++; if (char_width !== 12'd8) begin n_fail++; $display("FAIL reset_width: got %0d expected 8", char_width); end
    n_checks++; if (char_length !== 12'd16) begin n_fail++; $display("FAIL reset_length: got %0d expected 16", char_length); end
    n_checks++; if (start_y !== 10'h3FF) begin n_fail++; $display("FAIL reset_start_y: got %0d expected 1023", start_y); end
    n_checks++; if ({char_color, start_x, overlay_en, commit_ack, wr_err} !== 38'd0) begin
      n_fail++; $display("FAIL reset_zero: color=%0h x=%0d en=%0b ack=%0b err=%0b expected all 0",
                         char_color, start_x, overlay_en, commit_ack, wr_err); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_commit();
    wr_str(0, 9); wr_str(1, 70); wr_str(2, 0);
    wr_cfg(CFG_EN, 1); wr_cfg(CFG_X, 100); wr_cfg(CFG_Y, 50);
    n_checks++; if (overlay_en !== 1'b0) begin n_fail++; $display("FAIL shadow_leak: overlay_en got %0b expected 0", overlay_en); end
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n_checks++; if (commit_ack !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %0b expected 0", commit_ack); end
    tick();
    n_checks++; if (commit_ack !== 1'b1) begin n_fail++; $display("FAIL ack_first: got %0b expected 1", commit_ack); end
    n_checks++; if (overlay_en !== 1'b1 || start_y !== 10'd50 || start_x !== 11'd100) begin
      n_fail++; $display("FAIL first_cfg: en=%0b y=%0d x=%0d expected 1 50 100", overlay_en, start_y, start_x); end
    char_count = 6'd0;
    tick();
    n_checks++; if (commit_ack !== 1'b0) begin n_fail++; $display("FAIL ack_width: got %0b expected 0", commit_ack); end
    n_checks++; if (pattern_addr !== 13'd1032) begin n_fail++; $display("FAIL addr_c9: got %0d expected 1032", pattern_addr); end
    char_count = 6'd1;
    tick();
    n_checks++; if (pattern_addr !== 13'd0) begin n_fail++; $display("FAIL addr_c70: got %0d expected 0", pattern_addr); end
    char_count = 6'd2;
    tick();
    n_checks++; if (pattern_addr !== 13'd0) begin n_fail++; $display("FAIL addr_c0: got %0d expected 0", pattern_addr); end
  endtask

  task automatic test_midframe_commit();
    fval = 1'b1; tick(); tick();
    wr_cfg(CFG_COLOR, 24'hFF0000);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (commit_ack !== 1'b0 || char_color !== 24'h0) begin
        n_fail++; $display("FAIL midframe_hold: ack=%0b color=%0h expected 0 0", commit_ack, char_color); end
    end
    fval = 1'b0;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (commit_ack) begin got = 1'b1; break; end
      end
      n_checks++; if (got !== 1'b1 || char_color !== 24'hFF0000) begin
        n_fail++; $display("FAIL frame_end_commit: ack_seen=%0b color=%0h expected 1 ff0000", got, char_color); end
    end
  endtask

  task automatic test_glyph_map();
    int idx_t [6];
    int exp_t [6];
    idx_t = '{3, 59, 5, 60, 0, 63};
    exp_t = '{7224, 1024, 2056, 0, 1032, 0};
    wr_str(3, 63); wr_str(59, 8);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'd17;
    tick();
    wr_en = 1'b0;
    n_checks++; if (commit_ack !== 1'b1) begin n_fail++; $display("FAIL ack_with_write: got %0b expected 1", commit_ack); end
    for (int i = 0; i < 6; i++) begin
      char_count = IDX_W'(idx_t[i]);
      tick();
      n_checks++; if (pattern_addr !== ADDR_W'(exp_t[i])) begin
        n_fail++; $display("FAIL glyph_idx%0d: got %0d expected %0d", idx_t[i], pattern_addr, exp_t[i]); end
    end
  endtask

  task automatic test_merge();
    int acks;
    fval = 1'b1; tick(); tick();
    for (int k = 0; k < 3; k++) begin
      commit_req = 1'b1; tick(); commit_req = 1'b0; tick(); tick();
    end
    fval = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (commit_ack) acks++;
    end
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL merge_acks: got %0d expected 1", acks); end
  endtask

  task automatic test_wr_err();
    wr_str(60, 33);
    n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_addr60: got %0b expected 1", wr_err); end
    tick();
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %0b expected 0", wr_err); end
    wr_cfg(3'd7, 24'h00FF00);
    n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_sel7: got %0b expected 1", wr_err); end
    wr_cfg(CFG_X, 100);
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL err_valid: got %0b expected 0", wr_err); end
    commit_wait("wr_err");
    n_checks++; if (char_color !== 24'hFF0000 || start_x !== 11'd100) begin
      n_fail++; $display("FAIL err_shadow: color=%0h x=%0d expected ff0000 100", char_color, start_x); end
    char_count = 6'd0;
    tick(); tick();
    n_checks++; if (pattern_addr !== 13'd1032) begin n_fail++; $display("FAIL err_string: got %0d expected 1032", pattern_addr); end
  endtask

  task automatic test_disable();
    wr_str(0, 9);
    wr_cfg(CFG_EN, 0);
    commit_wait("disable");
    char_count = 6'd0;
    for (int i = 0; i < 8; i++) begin
      fval = i[0];
      tick();
      n_checks++; if (start_y !== 10'h3FF || overlay_en !== 1'b0 || dut.state_q !== ST_IDLE) begin
        n_fail++; $display("FAIL disabled_hold: y=%0d en=%0b state=%0d expected 1023 0 IDLE", start_y, overlay_en, dut.state_q); end
      if (i > 0) begin
        n_checks++; if (pattern_addr !== 13'd0) begin n_fail++; $display("FAIL disabled_addr: got %0d expected 0", pattern_addr); end
      end
    end
    fval = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    int acks;
    wr_cfg(CFG_EN, 1);
    commit_wait("reenable");
    fval = 1'b1; tick(); tick();
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (start_y !== 10'h3FF || overlay_en !== 1'b0 || char_color !== 24'h0 || start_x !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: y=%0d en=%0b color=%0h x=%0d expected 1023 0 0 0", start_y, overlay_en, char_color, start_x); end
    n_checks++; if (char_width !== 12'd8 || pattern_addr !== 13'd0 || dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL async_reset2: w=%0d addr=%0d state=%0d expected 8 0 IDLE", char_width, pattern_addr, dut.state_q); end
    #3 rst_n = 1'b1;
    fval = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (commit_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL lost_commit: got %0d acks expected 0", acks); end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_midframe_commit();
    test_glyph_map();
    test_merge();
    test_wr_err();
    test_disable();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
